// File: rtl/frac_valid_pkg.sv
// Shared definitions for the fractional-rate valid generator.
// Provides the default accumulator width, a packed NUM/DEN payload,
// the bit-offset helper for channel i of a packed per-channel bus
// (channel 0 in the MSBs) and the illegal-configuration predicate.
// NUM/DEN fields wider than NB_ACC_MAX are not supported by cfg_illegal.
package frac_valid_pkg;

  localparam int unsigned NB_ACC_DEF = 16;
  localparam int unsigned NB_ACC_MAX = 32;

  typedef logic [NB_ACC_MAX-1:0] cfg_field_t;

  typedef struct packed {
    cfg_field_t num;
    cfg_field_t den;
  } chan_cfg_t;

  // LSB position of channel idx inside a packed bus of n_ch fields of nb bits.
  function automatic int unsigned field_lsb(input int unsigned n_ch,
                                            input int unsigned nb,
                                            input int unsigned idx);
    return (n_ch - 1 - idx) * nb;
  endfunction

  // A channel cannot run with a zero denominator or a rate above one.
  function automatic logic cfg_illegal(input chan_cfg_t cfg);
    return (cfg.den == '0) || (cfg.num > cfg.den);
  endfunction

endpackage

// File: rtl/frac_valid_channel.sv
// One fractional-rate channel: shadow NUM/DEN, phase accumulator,
// configuration error flag and registered one-cycle valid pulse.
// Ports: clk, rst_n (async active-low), tick (prescaled base tick, already
// suppressed on load), load (latch num_in/den_in and restart), num_in,
// den_in, valid, cfg_err; with FRAC_VALID_SYNC_EN also pulse_c/active_c
// (combinational: pulses on this tick / channel takes part in sync).
module frac_valid_channel
  import frac_valid_pkg::*;
#(
  parameter int unsigned NB_ACC  = NB_ACC_DEF,
  parameter int unsigned DEF_NUM = 0,
  parameter int unsigned DEF_DEN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              load,
  input  logic [NB_ACC-1:0] num_in,
  input  logic [NB_ACC-1:0] den_in,
  output logic              valid,
  output logic              cfg_err
`ifdef FRAC_VALID_SYNC_EN
  ,
  output logic              pulse_c,
  output logic              active_c
`endif
);

  localparam int unsigned NB_SUM = NB_ACC + 1;
  localparam chan_cfg_t DEF_CFG = '{num: NB_ACC_MAX'(DEF_NUM), den: NB_ACC_MAX'(DEF_DEN)};

  logic [NB_ACC-1:0] num_q;
  logic [NB_ACC-1:0] den_q;
  logic [NB_ACC-1:0] acc_q;
  logic [NB_ACC-1:0] acc_d;
  logic [NB_SUM-1:0] sum_c;
  logic              hit_c;
  logic              valid_d;
  logic              cfg_err_d;
  chan_cfg_t         load_cfg_c;

  // acc < DEN always holds, so the extra sum bit is enough to avoid overflow.
  always_comb begin
    sum_c = NB_SUM'(acc_q) + NB_SUM'(num_q);
    hit_c = (sum_c >= NB_SUM'(den_q));
  end

  // Next accumulator / pulse; an illegal channel stays parked at zero.
  always_comb begin
    acc_d      = acc_q;
    valid_d    = 1'b0;
    load_cfg_c = '{num: NB_ACC_MAX'(num_in), den: NB_ACC_MAX'(den_in)};
    cfg_err_d  = cfg_illegal(load_cfg_c);
    if (tick && !cfg_err) begin
      valid_d = hit_c;
      acc_d   = hit_c ? NB_ACC'(sum_c - NB_SUM'(den_q)) : NB_ACC'(sum_c);
    end
  end

`ifdef FRAC_VALID_SYNC_EN
  // Sync participation: legal channels with a non-zero rate.
  always_comb begin
    pulse_c  = tick && !cfg_err && hit_c;
    active_c = !cfg_err && (num_q != '0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q   <= NB_ACC'(DEF_NUM);
      den_q   <= NB_ACC'(DEF_DEN);
      acc_q   <= '0;
      valid   <= 1'b0;
      cfg_err <= cfg_illegal(DEF_CFG);
    end else if (load) begin
      num_q   <= num_in;
      den_q   <= den_in;
      acc_q   <= '0;
      valid   <= 1'b0;
      cfg_err <= cfg_err_d;
    end else begin
      acc_q   <= acc_d;
      valid   <= valid_d;
    end
  end

endmodule

// File: rtl/frac_valid_generator.sv
// Multi-channel fractional-rate valid strobe generator.
// A shared prescaler produces a base tick every COUNT_SCALE enabled cycles;
// each channel emits valid pulses at NUM/DEN of that tick rate.
// Ports: i_clock, i_reset_n (async active-low), i_enable (run/freeze),
// i_load (latch i_num/i_den and restart everything), i_num/i_den
// (channel 0 in MSBs), o_valid (bit 0 = channel 0), o_cfg_err.
// Optional macro FRAC_VALID_SYNC_EN adds o_sync: pulses with o_valid when
// every legal non-zero-rate channel pulses on the same tick.
module frac_valid_generator
  import frac_valid_pkg::*;
#(
  parameter int unsigned COUNT_SCALE = 2,
  parameter int unsigned N_CH        = 2,
  parameter int unsigned NB_ACC      = NB_ACC_DEF,
  parameter int unsigned DEF_NUM     = 0,
  parameter int unsigned DEF_DEN     = 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic                   i_load,
  input  logic [N_CH*NB_ACC-1:0] i_num,
  input  logic [N_CH*NB_ACC-1:0] i_den,
  output logic [N_CH-1:0]        o_valid,
  output logic [N_CH-1:0]        o_cfg_err
`ifdef FRAC_VALID_SYNC_EN
  ,
  output logic                   o_sync
`endif
);

  localparam int unsigned CW = (COUNT_SCALE > 1) ? $clog2(COUNT_SCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_SCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_c;

  // Prescaler next state; load restarts it and swallows a coincident tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_c = 1'b0;
    if (i_load) begin
      cnt_d = '0;
    end else if (i_enable) begin
      tick_c = (cnt_q == CNT_LAST);
      cnt_d  = tick_c ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

`ifdef FRAC_VALID_SYNC_EN
  logic [N_CH-1:0] pulse_c;
  logic [N_CH-1:0] active_c;
  logic            sync_d;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam int unsigned LSB = field_lsb(N_CH, NB_ACC, i);
    frac_valid_channel #(
      .NB_ACC  (NB_ACC),
      .DEF_NUM (DEF_NUM),
      .DEF_DEN (DEF_DEN)
    ) u_ch (
      .clk     (i_clock),
      .rst_n   (i_reset_n),
      .tick    (tick_c),
      .load    (i_load),
      .num_in  (i_num[LSB +: NB_ACC]),
      .den_in  (i_den[LSB +: NB_ACC]),
      .valid   (o_valid[i]),
      .cfg_err (o_cfg_err[i])
`ifdef FRAC_VALID_SYNC_EN
      ,
      .pulse_c (pulse_c[i]),
      .active_c(active_c[i])
`endif
    );
  end

`ifdef FRAC_VALID_SYNC_EN
  // Alignment strobe: all participating channels hit on this tick.
  always_comb begin
    sync_d = tick_c && (active_c != '0) && ((pulse_c & active_c) == active_c);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) o_sync <= 1'b0;
    else            o_sync <= sync_d;
  end
`endif

endmodule

// File: tb/tb_frac_valid_generator.sv
// Bench for frac_valid_generator: two instances (COUNT_SCALE 2 and 1) share
// stimulus; a closed-form rate model predicts every output each cycle.
module tb_frac_valid_generator;

  localparam int unsigned NB = 16;

  logic          tb_clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          load;
  logic [2*NB-1:0] num_bus;
  logic [2*NB-1:0] den_bus;
  logic [1:0]    v2, e2, v1, e1;
`ifdef FRAC_VALID_SYNC_EN
  logic          s2, s1;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Model state: config shared by both instances, tick progress per instance
  int unsigned       m_num [2];
  int unsigned       m_den [2];
  logic [1:0]        m_err;
  longint unsigned   e_cnt [2];
  logic [1:0]        exp_v [2];
  logic              exp_s [2];

  always #5 tb_clock = ~tb_clock;

  frac_valid_generator #(.COUNT_SCALE(2), .N_CH(2), .NB_ACC(NB)) dut_s2 (
    .i_clock(tb_clock), .i_reset_n(reset_n), .i_enable(enable), .i_load(load),
    .i_num(num_bus), .i_den(den_bus), .o_valid(v2), .o_cfg_err(e2)
`ifdef FRAC_VALID_SYNC_EN
    , .o_sync(s2)
`endif
  );

  frac_valid_generator #(.COUNT_SCALE(1), .N_CH(2), .NB_ACC(NB)) dut_s1 (
    .i_clock(tb_clock), .i_reset_n(reset_n), .i_enable(enable), .i_load(load),
    .i_num(num_bus), .i_den(den_bus), .o_valid(v1), .o_cfg_err(e1)
`ifdef FRAC_VALID_SYNC_EN
    , .o_sync(s1)
`endif
  );

  function automatic longint unsigned scale_of(input int d);
    return (d == 0) ? 64'd2 : 64'd1;
  endfunction

  // Tick k produces a pulse iff floor(k*N/D) steps up at k.
  function automatic bit pulse_on(input longint unsigned k, input int unsigned n,
                                  input int unsigned dd);
    longint unsigned nn = 64'(n);
    longint unsigned de = 64'(dd);
    return ((k * nn) / de) > (((k - 1) * nn) / de);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_num[c] = 0; m_den[c] = 1; m_err[c] = 1'b0;
      e_cnt[c] = 0; exp_v[c] = 2'b00; exp_s[c] = 1'b0;
    end
  endtask

  // Advance one clock: predict registered outputs from inputs at this edge.
  task automatic step();
    logic [1:0] nv [2];
    logic       ns [2];
    logic [1:0] act;
    longint unsigned k;
    for (int d = 0; d < 2; d++) begin
      nv[d] = 2'b00; ns[d] = 1'b0;
      if (!load && enable) begin
        e_cnt[d] += 1;
        if ((e_cnt[d] % scale_of(d)) == 0) begin
          k = e_cnt[d] / scale_of(d);
          act = 2'b00;
          for (int c = 0; c < 2; c++) begin
            if (!m_err[c] && pulse_on(k, m_num[c], m_den[c])) nv[d][c] = 1'b1;
            if (!m_err[c] && m_num[c] != 0) act[c] = 1'b1;
          end
          ns[d] = (act != 2'b00) && ((nv[d] & act) == act);
        end
      end
    end
    if (load) begin
      for (int c = 0; c < 2; c++) begin
        m_num[c] = 32'(num_bus[(1 - c) * NB +: NB]);
        m_den[c] = 32'(den_bus[(1 - c) * NB +: NB]);
        m_err[c] = (m_den[c] == 0) || (m_num[c] > m_den[c]);
        e_cnt[c] = 0;
      end
    end
    @(posedge tb_clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_v[d] = nv[d];
      exp_s[d] = ns[d];
    end
  endtask

  task automatic do_load(input int unsigned n0, input int unsigned d0,
                         input int unsigned n1, input int unsigned d1);
    num_bus = {NB'(n0), NB'(n1)};
    den_bus = {NB'(d0), NB'(d1)};
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; num_bus = '0; den_bus = '0;
    model_reset();
    repeat (3) @(posedge tb_clock);
    #1;
    checks++;
    if ({v2, v1, e2, e1} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", {v2, v1, e2, e1}, 8'h00);
    end
    reset_n = 1'b1;
    enable = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      checks++;
      if ({v2, v1, e2, e1} !== {exp_v[0], exp_v[1], m_err, m_err}) begin
        failures++;
        $display("FAIL reset_defaults t=%0t got=%b want=%b", $time, {v2, v1, e2, e1},
                 {exp_v[0], exp_v[1], m_err, m_err});
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_rate_1_20();
    int first2 = 0, first1 = 0, cnt2 = 0, cnt1 = 0;
    enable = 1'b0;
    do_load(1, 20, 0, 1);
    enable = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      step();
      checks++;
      if ({v2, v1} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL rate_1_20_valid t=%0t got=%b want=%b", $time, {v2, v1}, {exp_v[0], exp_v[1]});
      end
      if (v2[0] === 1'b1) begin cnt2++; if (first2 == 0) first2 = n; end
      if (v1[0] === 1'b1) begin cnt1++; if (first1 == 0) first1 = n; end
    end
    checks++;
    if (first2 != 40) begin failures++; $display("FAIL rate_1_20_first_s2 got=%0d want=40", first2); end
    checks++;
    if (first1 != 20) begin failures++; $display("FAIL rate_1_20_first_s1 got=%0d want=20", first1); end
    checks++;
    if (cnt2 != 3) begin failures++; $display("FAIL rate_1_20_count_s2 got=%0d want=3", cnt2); end
    checks++;
    if (cnt1 != 6) begin failures++; $display("FAIL rate_1_20_count_s1 got=%0d want=6", cnt1); end
    enable = 1'b0;
  endtask

  task automatic test_rate_3_8();
    int cnt2 = 0, cnt1 = 0;
    logic [7:0] pat = 8'h00;
    int unsigned n1 = $urandom_range(0, 10);
    int unsigned d1 = $urandom_range((n1 == 0) ? 1 : n1, 12);
    enable = 1'b0;
    do_load(3, 8, n1, d1);
    enable = 1'b1;
    for (int n = 1; n <= 800; n++) begin
      step();
      checks++;
      if ({v2, v1} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL rate_3_8_valid t=%0t got=%b want=%b", $time, {v2, v1}, {exp_v[0], exp_v[1]});
      end
      if (v2[0] === 1'b1) cnt2++;
      if (v1[0] === 1'b1) cnt1++;
      if (n <= 8) pat[n - 1] = v1[0];
    end
    checks++;
    if (pat !== 8'b1010_0100) begin failures++; $display("FAIL rate_3_8_pattern got=%b want=%b", pat, 8'b1010_0100); end
    checks++;
    if (cnt1 != 300) begin failures++; $display("FAIL rate_3_8_count_s1 got=%0d want=300", cnt1); end
    checks++;
    if (cnt2 != 150) begin failures++; $display("FAIL rate_3_8_count_s2 got=%0d want=150", cnt2); end
    enable = 1'b0;
  endtask

  task automatic test_cfg_err();
    enable = 1'b0;
    do_load(7, 0, 5, 4);
    enable = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if ({e2, e1, v2, v1} !== 8'b1111_0000) begin
        failures++;
        $display("FAIL cfg_err_both t=%0t got=%b want=%b", $time, {e2, e1, v2, v1}, 8'b1111_0000);
      end
    end
    do_load(7, 0, 4, 4);
    for (int n = 0; n < 12; n++) begin
      step();
      checks++;
      if ({e2, e1, v1} !== 6'b01_01_10 || v2 !== exp_v[0]) begin
        failures++;
        $display("FAIL cfg_err_reload t=%0t got=%b want=%b", $time, {e2, e1, v2, v1},
                 {4'b0101, exp_v[0], 2'b10});
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_load_on_tick();
    int first2 = 0, first1 = 0;
    enable = 1'b0;
    do_load(1, 1, 1, 1);
    enable = 1'b1;
    repeat (3) step();
    // Cycle 3 ticks on both instances; dut_s1 still shows its prior pulse.
    checks++;
    if ({v2, v1} !== 4'b0011) begin
      failures++;
      $display("FAIL load_tick_before got=%b want=%b", {v2, v1}, 4'b0011);
    end
    do_load(1, 2, 2, 3);
    checks++;
    if ({v2, v1} !== 4'b0000) begin
      failures++;
      $display("FAIL load_tick_discard got=%b want=%b", {v2, v1}, 4'b0000);
    end
    for (int n = 1; n <= 14; n++) begin
      step();
      checks++;
      if ({v2, v1} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL load_tick_valid t=%0t got=%b want=%b", $time, {v2, v1}, {exp_v[0], exp_v[1]});
      end
      if (v2[0] === 1'b1 && first2 == 0) first2 = n;
      if (v1[0] === 1'b1 && first1 == 0) first1 = n;
    end
    checks++;
    if (first2 != 4 || first1 != 2) begin
      failures++;
      $display("FAIL load_tick_restart got=%0d/%0d want=4/2", first2, first1);
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_gap();
    int first2 = 0, first1 = 0;
    enable = 1'b0;
    do_load(1, 20, 0, 1);
    for (int n = 1; n <= 60; n++) begin
      enable = ((n - 1) < 15 || (n - 1) > 24);
      step();
      checks++;
      if ({v2, v1} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL enable_gap_valid t=%0t got=%b want=%b", $time, {v2, v1}, {exp_v[0], exp_v[1]});
      end
      if (v2[0] === 1'b1 && first2 == 0) first2 = n;
      if (v1[0] === 1'b1 && first1 == 0) first1 = n;
    end
    checks++;
    if (first2 != 50 || first1 != 30) begin
      failures++;
      $display("FAIL enable_gap_delay got=%0d/%0d want=50/30", first2, first1);
    end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    enable = 1'b0;
    do_load(3, 4, 1, 0);
    enable = 1'b1;
    repeat (7) step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({v2, v1, e2, e1} !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_immediate got=%b want=%b", {v2, v1, e2, e1}, 8'h00);
    end
    model_reset();
    @(posedge tb_clock);
    #1;
    reset_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      checks++;
      if ({v2, v1, e2, e1} !== {exp_v[0], exp_v[1], m_err, m_err}) begin
        failures++;
        $display("FAIL async_reset_defaults t=%0t got=%b want=%b", $time, {v2, v1, e2, e1},
                 {exp_v[0], exp_v[1], m_err, m_err});
      end
    end
    enable = 1'b0;
  endtask

`ifdef FRAC_VALID_SYNC_EN
  task automatic test_sync();
    int cs2 = 0, cs1 = 0;
    enable = 1'b0;
    do_load(1, 2, 1, 3);
    enable = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      step();
      checks++;
      if ({s2, s1, v2, v1} !== {exp_s[0], exp_s[1], exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL sync_model t=%0t got=%b want=%b", $time, {s2, s1, v2, v1},
                 {exp_s[0], exp_s[1], exp_v[0], exp_v[1]});
      end
      if (s2 === 1'b1) cs2++;
      if (s1 === 1'b1) cs1++;
    end
    checks++;
    if (cs1 != 10 || cs2 != 5) begin
      failures++;
      $display("FAIL sync_count got=%0d/%0d want=10/5", cs1, cs2);
    end
    enable = 1'b0;
  endtask
`endif

  task automatic test_random();
    int unsigned d0, d1, n0, n1;
    for (int n = 0; n < 2000; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) begin
        d0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
        d1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
        n0 = ($urandom_range(0, 7) == 0) ? d0 + 1 : $urandom_range(0, d0);
        n1 = ($urandom_range(0, 7) == 0) ? d1 + 1 : $urandom_range(0, d1);
        num_bus = {NB'(n0), NB'(n1)};
        den_bus = {NB'(d0), NB'(d1)};
        load = 1'b1;
      end
      step();
      load = 1'b0;
      checks++;
      if ({v2, v1, e2, e1} !== {exp_v[0], exp_v[1], m_err, m_err}) begin
        failures++;
        $display("FAIL random_outputs t=%0t got=%b want=%b", $time, {v2, v1, e2, e1},
                 {exp_v[0], exp_v[1], m_err, m_err});
      end
`ifdef FRAC_VALID_SYNC_EN
      checks++;
      if ({s2, s1} !== {exp_s[0], exp_s[1]}) begin
        failures++;
        $display("FAIL random_sync t=%0t got=%b want=%b", $time, {s2, s1}, {exp_s[0], exp_s[1]});
      end
`endif
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rate_1_20();
    test_rate_3_8();
    test_cfg_err();
    test_load_on_tick();
    test_enable_gap();
    test_async_reset();
`ifdef FRAC_VALID_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
